// File: rtl/csi_rx_capture_ctrl_pkg.sv
// csi_rx_capture_ctrl_pkg
// Shared definitions for the CSI-2 receive capture sequencer: the 3-bit
// sequencer state encoding and the bit positions inside the sticky err_code.
package csi_rx_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_FS = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_DONE    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  localparam int ERR_LINE_LEN = 0;  // words in a line differ from config
  localparam int ERR_LINE_CNT = 1;  // lines in a frame differ from config
  localparam int ERR_TIMEOUT  = 2;  // link stalled mid-frame
  localparam int ERR_NO_FE    = 3;  // frame start seen before frame end

endpackage

// File: rtl/csi_rx_capture_ctrl_if.sv
// csi_rx_capture_ctrl_if
// Link between the packet handler / line buffer and the capture sequencer.
//   vsync, in_frame, in_line, payload_enable : registered packet-handler status
//   ph_reset       : reset pulse back to the packet handler and aligners
//   capture_enable : line-buffer write enable, aligned with the payload word
// master = packet-handler side, slave = capture sequencer.
interface csi_rx_capture_ctrl_if;
  logic vsync;
  logic in_frame;
  logic in_line;
  logic payload_enable;
  logic ph_reset;
  logic capture_enable;

  modport master (
    output vsync, in_frame, in_line, payload_enable,
    input  ph_reset, capture_enable
  );

  modport slave (
    input  vsync, in_frame, in_line, payload_enable,
    output ph_reset, capture_enable
  );
endinterface

// File: rtl/csi_rx_watchdog.sv
// csi_rx_watchdog
// Loadable down-counter used as the link-stall watchdog.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : reload the counter with load_value (activity seen)
//   enable         : count down this cycle
//   load_value     : reload value (timeout length minus one)
//   expired        : counter has reached zero while enabled
module csi_rx_watchdog #(
  parameter int CNT_W = 24
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] load_value,
  output logic             expired
);

  logic [CNT_W-1:0] r_cnt;

  // Reload on activity, otherwise count down while enabled and stop at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (clear) begin
      r_cnt <= load_value;
    end else if (enable && (r_cnt != {CNT_W{1'b0}})) begin
      r_cnt <= r_cnt - 1'b1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Expiry is independent of clear so the owner can gate it without a loop.
  assign expired = enable && (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/csi_rx_capture_ctrl.sv
// csi_rx_capture_ctrl
// Frame capture sequencer: arms/disarms capture, counts payload words and
// lines against the configured frame size, gates payload into the line buffer
// and resets the packet handler when the link stalls mid-frame.
//   clock, reset_n        : word clock, asynchronous active-low reset
//   cfg_words_per_line    : expected payload words per line
//   cfg_lines_per_frame   : expected lines per frame
//   cfg_continuous        : re-arm automatically after each frame
//   arm, abort            : single-cycle control pulses
//   ph_if (slave)         : packet-handler status in, ph_reset/capture_enable out
//   busy                  : any state other than IDLE
//   frame_done, frame_err : single-cycle frame result pulses
//   err_code              : sticky error bits (see package for indices)
//   line_count            : lines completed in the current frame
//   frame_count           : good frames since reset (wraps)
module csi_rx_capture_ctrl
  import csi_rx_capture_ctrl_pkg::*;
#(
  parameter int          WORD_W         = 12,
  parameter int          LINE_W         = 12,
  parameter logic [23:0] TIMEOUT        = 24'd1_000_000,
  parameter int          RECOVER_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] cfg_words_per_line,
  input  logic [LINE_W-1:0] cfg_lines_per_frame,
  input  logic              cfg_continuous,
  input  logic              arm,
  input  logic              abort,
  csi_rx_capture_ctrl_if.slave ph_if,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [3:0]        err_code,
  output logic [LINE_W-1:0] line_count,
  output logic [15:0]       frame_count
);

  localparam logic [7:0] REC_LOAD = 8'(RECOVER_CYCLES - 1);

  state_e            r_state, w_next;
  logic [WORD_W-1:0] r_word_cnt, w_word_nxt;
  logic [LINE_W-1:0] r_line_cnt, w_line_nxt;
  logic [3:0]        r_err, w_err_nxt;
  logic [15:0]       r_frame_cnt;
  logic [7:0]        r_rec_cnt;
  logic              r_in_line_d, r_in_frame_d;
  logic              r_frame_done, r_frame_err, r_ph_reset, r_busy, r_wait_wd;
  logic              w_err_pulse, w_cap, w_line_end, w_frame_end;
  logic              w_wd_en, w_wd_clr, w_wd_expired, w_timeout;

  assign w_cap       = (r_state == ST_ACTIVE) && ph_if.in_line && ph_if.payload_enable;
  assign w_line_end  = r_in_line_d && !ph_if.in_line;
  assign w_frame_end = r_in_frame_d && !ph_if.in_frame;

  // WAIT_FS entered straight from IDLE waits on the sensor indefinitely, so
  // the watchdog only runs there after a continuous-mode re-arm.
  assign w_wd_en   = (r_state == ST_ACTIVE) || ((r_state == ST_WAIT_FS) && r_wait_wd);
  assign w_wd_clr  = w_cap || ph_if.vsync || (w_next != r_state);
  assign w_timeout = w_wd_expired && !w_cap && !ph_if.vsync;

  csi_rx_watchdog #(.CNT_W(24)) u_watchdog (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (w_wd_clr),
    .enable     (w_wd_en),
    .load_value (TIMEOUT - 24'd1),
    .expired    (w_wd_expired)
  );

  // Next-state, counter and error-bit decisions for the sequencer.
  always_comb begin
    w_next      = r_state;
    w_word_nxt  = r_word_cnt;
    w_line_nxt  = r_line_cnt;
    w_err_nxt   = r_err;
    w_err_pulse = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (abort) begin
          w_next = ST_RECOVER;
        end else if (arm) begin
          w_next    = ST_WAIT_FS;
          w_err_nxt = 4'b0000;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WAIT_FS: begin
        if (abort) begin
          w_next = ST_RECOVER;
        end else if (w_timeout) begin
          w_err_nxt[ERR_TIMEOUT] = 1'b1;
          w_err_pulse            = 1'b1;
          w_next                 = ST_RECOVER;
        end else if (ph_if.vsync) begin
          w_next     = ST_ACTIVE;
          w_word_nxt = {WORD_W{1'b0}};
          w_line_nxt = {LINE_W{1'b0}};
        end else begin
          w_next = ST_WAIT_FS;
        end
      end
      ST_ACTIVE: begin
        if (abort) begin
          w_next = ST_RECOVER;
        end else if (w_timeout) begin
          w_err_nxt[ERR_TIMEOUT] = 1'b1;
          w_err_pulse            = 1'b1;
          w_next                 = ST_RECOVER;
        end else if (ph_if.vsync) begin
          // New frame start without a frame end: restart counting in place.
          w_err_nxt[ERR_NO_FE] = 1'b1;
          w_err_pulse          = 1'b1;
          w_word_nxt           = {WORD_W{1'b0}};
          w_line_nxt           = {LINE_W{1'b0}};
        end else begin
          if (w_cap) begin
            w_word_nxt = (&r_word_cnt) ? r_word_cnt : r_word_cnt + 1'b1;
          end else begin
            w_word_nxt = r_word_cnt;
          end
          if (w_line_end) begin
            if (r_word_cnt != cfg_words_per_line) begin
              w_err_nxt[ERR_LINE_LEN] = 1'b1;
            end else begin
              w_err_nxt[ERR_LINE_LEN] = r_err[ERR_LINE_LEN];
            end
            w_word_nxt = {WORD_W{1'b0}};
            w_line_nxt = (&r_line_cnt) ? r_line_cnt : r_line_cnt + 1'b1;
          end else begin
            w_line_nxt = r_line_cnt;
          end
          // Checked against w_line_nxt so a coincident line end is included.
          if (w_frame_end) begin
            if (w_line_nxt != cfg_lines_per_frame) begin
              w_err_nxt[ERR_LINE_CNT] = 1'b1;
            end else begin
              w_err_nxt[ERR_LINE_CNT] = r_err[ERR_LINE_CNT];
            end
            w_next = ST_DONE;
          end else begin
            w_next = ST_ACTIVE;
          end
        end
      end
      ST_DONE: begin
        if (abort) begin
          w_next = ST_RECOVER;
        end else if (cfg_continuous) begin
          w_next = ST_WAIT_FS;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RECOVER: begin
        if (abort) begin
          w_next = ST_RECOVER;
        end else if (r_rec_cnt == 8'd0) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RECOVER;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_word_cnt   <= {WORD_W{1'b0}};
      r_line_cnt   <= {LINE_W{1'b0}};
      r_err        <= 4'b0000;
      r_frame_cnt  <= 16'd0;
      r_rec_cnt    <= 8'd0;
      r_in_line_d  <= 1'b0;
      r_in_frame_d <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_ph_reset   <= 1'b0;
      r_busy       <= 1'b0;
      r_wait_wd    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_word_cnt   <= w_word_nxt;
      r_line_cnt   <= w_line_nxt;
      r_err        <= w_err_nxt;
      r_in_line_d  <= ph_if.in_line;
      r_in_frame_d <= ph_if.in_frame;
      // Result pulses are launched on entry to DONE so they sit in DONE.
      r_frame_done <= (w_next == ST_DONE) && (w_err_nxt == 4'b0000);
      r_frame_err  <= w_err_pulse || ((w_next == ST_DONE) && (w_err_nxt != 4'b0000));
      r_ph_reset   <= (w_next == ST_RECOVER);
      r_busy       <= (w_next != ST_IDLE);
      if ((r_state == ST_DONE) && (r_err == 4'b0000)) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
      if ((w_next == ST_RECOVER) && ((r_state != ST_RECOVER) || abort)) begin
        r_rec_cnt <= REC_LOAD;
      end else if ((r_state == ST_RECOVER) && (r_rec_cnt != 8'd0)) begin
        r_rec_cnt <= r_rec_cnt - 8'd1;
      end else begin
        r_rec_cnt <= r_rec_cnt;
      end
      // Remember whether this WAIT_FS stay began from a continuous re-arm.
      if (w_next == ST_WAIT_FS) begin
        r_wait_wd <= (r_state == ST_WAIT_FS) ? r_wait_wd : (r_state == ST_DONE);
      end else begin
        r_wait_wd <= 1'b0;
      end
    end
  end

  assign ph_if.capture_enable = w_cap;
  assign ph_if.ph_reset       = r_ph_reset;
  assign busy                 = r_busy;
  assign frame_done           = r_frame_done;
  assign frame_err            = r_frame_err;
  assign err_code             = r_err;
  assign line_count           = r_line_cnt;
  assign frame_count          = r_frame_cnt;

endmodule
